// File: rtl/rule_scheduler.sv
// rule_scheduler: picks one enabled rule per cycle for a Murphi-derived system.
// The default build scans round-robin from the last fired rule. Defining the
// macro RULE_SCHED_LFSR_EN starts each scan from a 4-bit LFSR instead.
// The unit declares deadlock after DEADLOCK_CYCLES consecutive idle cycles.
// Only reset leaves the DEAD state.
module rule_scheduler #(
    parameter int NUM_RULES       = 15,
    parameter int DEADLOCK_CYCLES = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_RULES-1:0] io_guard,
    input  logic                 io_stall,
    output logic [3:0]           io_en_a,
    output logic                 io_fire,
    output logic                 io_deadlock,
    output logic [1:0]           io_state
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  ptr_r;
    logic [3:0]  ptr_s;
    logic [7:0]  idle_r;
    logic [7:0]  idle_s;
    logic [3:0]  en_r;
    logic [3:0]  en_s;
    logic        fire_r;
    logic        dead_r;
    logic        dead_s;
    logic [3:0]  base_s;
    logic [3:0]  hi_s;
    logic [3:0]  lo_s;
    logic        found_hi_s;
    logic [3:0]  sel_s;
    logic        any_s;

`ifdef RULE_SCHED_LFSR_EN
    logic [3:0]  lfsr_r;
    logic [3:0]  lfsr_s;
`endif

    assign any_s = |io_guard;

    // Scan origin and winner: the lowest enabled index above base, else wrap to the lowest enabled.
    always_comb begin
`ifdef RULE_SCHED_LFSR_EN
        base_s = 4'(int'(lfsr_r) % NUM_RULES);
`else
        base_s = ptr_r;
`endif
        hi_s       = 4'd0;
        lo_s       = 4'd0;
        found_hi_s = 1'b0;
        for (int k = NUM_RULES - 1; k >= 0; k--) begin
            if (io_guard[k]) begin
                lo_s = 4'(k + 1);
                if ((k + 1) > int'(base_s)) begin
                    hi_s       = 4'(k + 1);
                    found_hi_s = 1'b1;
                end else begin
                    hi_s = hi_s;
                end
            end else begin
                lo_s = lo_s;
            end
        end
        sel_s = found_hi_s ? hi_s : lo_s;
    end

    // Next-state and next-output logic; HOLD with stall released behaves exactly like RUN.
    always_comb begin
        state_s = state_r;
        en_s    = 4'd0;
        ptr_s   = ptr_r;
        idle_s  = idle_r;
        dead_s  = dead_r;
`ifdef RULE_SCHED_LFSR_EN
        lfsr_s  = lfsr_r;
`endif
        case (state_r)
            ST_INIT: begin
                state_s = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (io_stall) begin
                    // Stall wins even when every guard is low, so idle counting pauses.
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_RUN;
`ifdef RULE_SCHED_LFSR_EN
                    lfsr_s  = {lfsr_r[2:0], lfsr_r[3] ^ lfsr_r[2]};
`endif
                    if (any_s) begin
                        en_s   = sel_s;
                        ptr_s  = sel_s;
                        idle_s = 8'd0;
                    end else begin
                        idle_s = idle_r + 8'd1;
                        if (idle_s == 8'(DEADLOCK_CYCLES)) begin
                            state_s = ST_DEAD;
                            dead_s  = 1'b1;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                end
            end
            ST_DEAD: begin
                state_s = ST_DEAD;
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_INIT;
            ptr_r   <= 4'd0;
            idle_r  <= 8'd0;
            en_r    <= 4'd0;
            fire_r  <= 1'b0;
            dead_r  <= 1'b0;
`ifdef RULE_SCHED_LFSR_EN
            lfsr_r  <= 4'b1001;
`endif
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            idle_r  <= idle_s;
            en_r    <= en_s;
            fire_r  <= (en_s != 4'd0);
            dead_r  <= dead_s;
`ifdef RULE_SCHED_LFSR_EN
            lfsr_r  <= lfsr_s;
`endif
        end
    end

    assign io_en_a     = en_r;
    assign io_fire     = fire_r;
    assign io_deadlock = dead_r;
    assign io_state    = state_r;

endmodule

// File: tb/tb_rule_scheduler.sv
// Bench for rule_scheduler (round-robin build, NUM_RULES=4, DEADLOCK_CYCLES=8).
// A cycle-level reference model is compared against the DUT on every falling edge.
// Literal expectations pin the documented sequences.
module tb_rule_scheduler;

    localparam int NR = 4;
    localparam int DL = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] io_guard = '0;
    logic          io_stall = 1'b0;
    logic [3:0]    io_en_a;
    logic          io_fire;
    logic          io_deadlock;
    logic [1:0]    io_state;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit m_valid = 1'b0;
    int m_state = 0;   // 0 INIT 1 RUN 2 HOLD 3 DEAD
    int m_p     = 0;
    int m_idle  = 0;
    int m_en    = 0;
    bit m_dead  = 1'b0;

    rule_scheduler #(.NUM_RULES(NR), .DEADLOCK_CYCLES(DL)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_guard    (io_guard),
        .io_stall    (io_stall),
        .io_en_a     (io_en_a),
        .io_fire     (io_fire),
        .io_deadlock (io_deadlock),
        .io_state    (io_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // next rule after p: walk forward around the ring and take the first enabled one
    function automatic int pick(input logic [NR-1:0] g, input int p);
        for (int step = 1; step <= NR; step++) begin
            int cand;
            cand = ((p + step - 1) % NR) + 1;
            if (g[cand-1]) return cand;
        end
        return 0;
    endfunction

    task automatic model_step(input logic [NR-1:0] g, input bit s, input bit r);
        if (r) begin
            m_state = 0; m_p = 0; m_idle = 0; m_en = 0; m_dead = 1'b0;
        end else if (m_state == 0) begin
            m_state = 1; m_en = 0;
        end else if (m_state == 3) begin
            m_en = 0;
        end else if (s) begin
            m_state = 2; m_en = 0;
        end else begin
            m_state = 1;
            if (g == '0) begin
                m_en = 0;
                m_idle = m_idle + 1;
                if (m_idle == DL) begin
                    m_state = 3; m_dead = 1'b1;
                end
            end else begin
                m_en = pick(g, m_p);
                m_p = m_en;
                m_idle = 0;
            end
        end
        m_valid = 1'b1;
    endtask

    // one clock: drive inputs on the falling edge, step the model on the rising edge
    task automatic cyc(input logic [NR-1:0] g, input bit s, input bit r);
        @(negedge clock);
        io_guard = g;
        io_stall = s;
        reset    = r;
        @(posedge clock);
        model_step(g, s, r);
        #1;
    endtask

    // compare process: every falling edge once the model is live
    always @(negedge clock) begin
        if (m_valid) begin
            chk("en_a",     int'(io_en_a),     m_en);
            chk("fire",     int'(io_fire),     (m_en != 0) ? 1 : 0);
            chk("deadlock", int'(io_deadlock), int'(m_dead));
            chk("state",    int'(io_state),    m_state);
        end
    end

    initial begin
        int exp_rr[5];
        logic [NR-1:0] tbl[10];
        exp_rr = '{1, 2, 3, 4, 1};
        tbl = '{4'b1010, 4'b0001, 4'b0000, 4'b1000, 4'b0110,
                4'b1111, 4'b0011, 4'b0000, 4'b1001, 4'b0100};

        // all guards high: INIT then 1,2,3,4,1
        cyc(4'b1111, 1'b0, 1'b1);
        chk("lit_reset_en", int'(io_en_a), 0);
        chk("lit_reset_state", int'(io_state), 0);
        chk("lit_reset_dead", int'(io_deadlock), 0);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("lit_init_en", int'(io_en_a), 0);
        chk("lit_run_state", int'(io_state), 1);
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 1'b0, 1'b0);
            chk("lit_rr_seq", int'(io_en_a), exp_rr[i]);
        end

        // guards 0101: alternate 1,3 with fire held high
        cyc(4'b0101, 1'b0, 1'b1);
        cyc(4'b0101, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0101, 1'b0, 1'b0);
            chk("lit_alt_seq", int'(io_en_a), (i % 2 == 0) ? 1 : 3);
            chk("lit_alt_fire", int'(io_fire), 1);
        end

        // fire 1,2 then stall for 3 cycles, release -> 3
        cyc(4'b1111, 1'b0, 1'b1);
        cyc(4'b1111, 1'b0, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("lit_before_stall", int'(io_en_a), 2);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 1'b1, 1'b0);
            chk("lit_stall_en", int'(io_en_a), 0);
            chk("lit_stall_state", int'(io_state), 2);
        end
        cyc(4'b1111, 1'b0, 1'b0);
        chk("lit_release_en", int'(io_en_a), 3);

        // reset with P=3 mid-RUN: first fire afterwards is rule 1
        cyc(4'b1111, 1'b0, 1'b1);
        chk("lit_midreset_en", int'(io_en_a), 0);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("lit_midreset_init", int'(io_en_a), 0);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("lit_midreset_first", int'(io_en_a), 1);

        // single guard repeatedly selected, including when it equals P
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0100, 1'b0, 1'b0);
            chk("lit_single", int'(io_en_a), 3);
        end

        // idle counting pauses while stalled with all guards low
        for (int i = 0; i < 5; i++) cyc(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b1, 1'b0);
        chk("lit_idle_stall_state", int'(io_state), 2);
        for (int i = 0; i < 2; i++) cyc(4'b0000, 1'b0, 1'b0);
        chk("lit_idle7_dead", int'(io_deadlock), 0);
        cyc(4'b0000, 1'b0, 1'b0);
        chk("lit_idle8_dead", int'(io_deadlock), 1);
        chk("lit_idle8_state", int'(io_state), 3);

        // plain 8-cycle deadlock from fresh reset, then DEAD ignores guards and stall
        cyc(4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(4'b0000, 1'b0, 1'b0);
        chk("lit_dead_flag", int'(io_deadlock), 1);
        chk("lit_dead_state", int'(io_state), 3);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b1111, (i % 2 == 1), 1'b0);
            chk("lit_dead_en", int'(io_en_a), 0);
        end
        cyc(4'b1111, 1'b0, 1'b1);
        chk("lit_dead_cleared", int'(io_deadlock), 0);
        cyc(4'b1111, 1'b0, 1'b0);

        // mixed guard patterns with occasional stalls, checked by the model only
        for (int i = 0; i < 20; i++) cyc(tbl[i % 10], (i % 7 == 3), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
